// File: rtl/riscv_pkg.sv
// Shared encodings for the execute stage: ALU codes,
// control-word bit positions and branch funct3 values.
package riscv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    localparam int CW_W      = 13;
    localparam int CW_SRCA   = 12;
    localparam int CW_SRCB   = 11;
    localparam int CW_BRANCH = 10;
    localparam int CW_JAL    = 9;
    localparam int CW_JALR   = 8;
    localparam int CW_F3_HI  = 7;
    localparam int CW_F3_LO  = 5;
    localparam int CW_MW_HI  = 4;

    localparam int CWM_W      = 5;
    localparam int CWM_MEM_RD = 4;
    localparam int CWM_MEM_WR = 3;
    localparam int CWM_WB_HI  = 2;
    localparam int CWM_WB_LO  = 1;
    localparam int CWM_RF_WR  = 0;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/execute_unit_alu.sv
// Combinational ALU; undefined codes fall back to ADD and
// shift amounts come from the low five bits of B only.
module alu
    import riscv_pkg::*;
#(
    parameter int nbits = 32
) (
    input  logic [nbits-1:0] A,
    input  logic [nbits-1:0] B,
    input  logic [3:0]       aluop,
    output logic [nbits-1:0] result
);

    logic [4:0] shamt;

    assign shamt = B[4:0];

    always_comb begin
        result = A + B;
        case (aluop)
            ALU_ADD:   result = A + B;
            ALU_SUB:   result = A - B;
            ALU_AND:   result = A & B;
            ALU_OR:    result = A | B;
            ALU_XOR:   result = A ^ B;
            ALU_SLL:   result = A << shamt;
            ALU_SRL:   result = A >> shamt;
            ALU_SRA:   result = $unsigned($signed(A) >>> shamt);
            ALU_SLT:   result = {{(nbits-1){1'b0}}, $signed(A) < $signed(B)};
            ALU_SLTU:  result = {{(nbits-1){1'b0}}, A < B};
            ALU_PASSB: result = B;
            default:   result = A + B;
        endcase
    end

endmodule

// File: rtl/execute_unit.sv
// EX stage: operand forwarding, branch/jump resolution and
// the EX/MEM pipeline register.
module execute_unit
    import riscv_pkg::*;
#(
    parameter int nbits = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [nbits-1:0] r1,
    input  logic [nbits-1:0] r2,
    input  logic [nbits-1:0] imm_in,
    input  logic [nbits-1:0] pc_in,
    input  logic [nbits-1:0] npc_in,
    input  logic [12:0]      cw_exe,
    input  logic [3:0]       aluop_exe,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    input  logic [4:0]       rd_in,
    input  logic [nbits-1:0] wb_data,
    input  logic [4:0]       wb_rd,
    input  logic             wb_we,
    output logic [nbits-1:0] alu_mem,
    output logic [nbits-1:0] store_data_mem,
    output logic [nbits-1:0] npc_mem,
    output logic [4:0]       rd_mem,
    output logic [4:0]       cw_mem,
    output logic             flush,
    output logic [nbits-1:0] target
);

    logic             mem_fwd_ok;
    logic             wb_fwd_ok;
    logic [nbits-1:0] fwd_a;
    logic [nbits-1:0] fwd_b;
    logic [nbits-1:0] op_a;
    logic [nbits-1:0] op_b;
    logic [nbits-1:0] alu_res;
    logic [nbits-1:0] jalr_sum;
    logic [2:0]       funct3;
    logic             taken;
    logic             redirect;

    // Loads in MEM have no data yet, so they never feed the bypass.
    assign mem_fwd_ok = cw_mem[CWM_RF_WR] & ~cw_mem[CWM_MEM_RD]
                      & (rd_mem != 5'd0);
    assign wb_fwd_ok  = wb_we & (wb_rd != 5'd0);

    always_comb begin
        fwd_a = r1;
        if (mem_fwd_ok && rd_mem == rs1_addr)
            fwd_a = alu_mem;
        else if (wb_fwd_ok && wb_rd == rs1_addr)
            fwd_a = wb_data;
    end

    always_comb begin
        fwd_b = r2;
        if (mem_fwd_ok && rd_mem == rs2_addr)
            fwd_b = alu_mem;
        else if (wb_fwd_ok && wb_rd == rs2_addr)
            fwd_b = wb_data;
    end

    assign op_a = cw_exe[CW_SRCA] ? pc_in  : fwd_a;
    assign op_b = cw_exe[CW_SRCB] ? imm_in : fwd_b;

    alu #(.nbits(nbits)) u_alu (
        .A      (op_a),
        .B      (op_b),
        .aluop  (aluop_exe),
        .result (alu_res)
    );

    assign funct3 = cw_exe[CW_F3_HI:CW_F3_LO];

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (fwd_a == fwd_b);
            F3_BNE:  taken = (fwd_a != fwd_b);
            F3_BLT:  taken = ($signed(fwd_a) <  $signed(fwd_b));
            F3_BGE:  taken = ($signed(fwd_a) >= $signed(fwd_b));
            F3_BLTU: taken = (fwd_a <  fwd_b);
            F3_BGEU: taken = (fwd_a >= fwd_b);
            default: taken = 1'b0;
        endcase
    end

    assign jalr_sum = fwd_a + imm_in;

    always_comb begin
        redirect = 1'b0;
        target   = pc_in + imm_in;
        priority case (1'b1)
            cw_exe[CW_JALR]: begin
                redirect = 1'b1;
                target   = {jalr_sum[nbits-1:1], 1'b0};
            end
            cw_exe[CW_JAL]: begin
                redirect = 1'b1;
            end
            cw_exe[CW_BRANCH]: begin
                redirect = taken;
            end
            default: begin
                redirect = 1'b0;
            end
        endcase
    end

    assign flush = rst & redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_mem        <= '0;
            store_data_mem <= '0;
            npc_mem        <= '0;
            rd_mem         <= '0;
            cw_mem         <= '0;
        end else begin
            alu_mem        <= alu_res;
            store_data_mem <= fwd_b;
            npc_mem        <= npc_in;
            rd_mem         <= rd_in;
            cw_mem         <= cw_exe[CW_MW_HI:0];
        end
    end

endmodule

// File: tb/tb_execute_unit.sv
// Directed bench for execute_unit: driver queues expectations,
// a monitor compares combinational and EX/MEM outputs.
module tb_execute_unit;

    logic        clk;
    logic        rst;
    logic [31:0] r1, r2, imm_in, pc_in, npc_in;
    logic [12:0] cw_exe;
    logic [3:0]  aluop_exe;
    logic [4:0]  rs1_addr, rs2_addr, rd_in;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [31:0] alu_mem, store_data_mem, npc_mem;
    logic [4:0]  rd_mem, cw_mem;
    logic        flush;
    logic [31:0] target;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] st;
        logic [31:0] npc;
        logic [4:0]  rd;
        logic [4:0]  cw;
        logic        fl;
        logic [31:0] tg;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    execute_unit #(.nbits(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .r1             (r1),
        .r2             (r2),
        .imm_in         (imm_in),
        .pc_in          (pc_in),
        .npc_in         (npc_in),
        .cw_exe         (cw_exe),
        .aluop_exe      (aluop_exe),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rd_in          (rd_in),
        .wb_data        (wb_data),
        .wb_rd          (wb_rd),
        .wb_we          (wb_we),
        .alu_mem        (alu_mem),
        .store_data_mem (store_data_mem),
        .npc_mem        (npc_mem),
        .rd_mem         (rd_mem),
        .cw_mem         (cw_mem),
        .flush          (flush),
        .target         (target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(
        input logic [31:0] a_r1, a_r2, a_imm, a_pc, a_npc,
        input logic [12:0] a_cw,
        input logic [3:0]  a_op,
        input logic [4:0]  a_rs1, a_rs2, a_rd,
        input logic [31:0] a_wbd,
        input logic [4:0]  a_wbr,
        input logic        a_wbwe,
        input logic [31:0] e_alu, e_st,
        input logic        e_fl,
        input logic [31:0] e_tg
    );
        exp_t e;
        @(negedge clk);
        r1 = a_r1; r2 = a_r2; imm_in = a_imm;
        pc_in = a_pc; npc_in = a_npc;
        cw_exe = a_cw; aluop_exe = a_op;
        rs1_addr = a_rs1; rs2_addr = a_rs2; rd_in = a_rd;
        wb_data = a_wbd; wb_rd = a_wbr; wb_we = a_wbwe;
        e.alu = e_alu; e.st = e_st; e.npc = a_npc;
        e.rd = a_rd; e.cw = a_cw[4:0];
        e.fl = e_fl; e.tg = e_tg;
        q.push_back(e);
    endtask

    // Monitor: combinational outputs mid-low phase, registers after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                e = q[0];
                chk("flush", {31'd0, flush}, {31'd0, e.fl});
                if (e.fl)
                    chk("target", target, e.tg);
            end
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("alu_mem", alu_mem, e.alu);
                chk("store_data_mem", store_data_mem, e.st);
                chk("npc_mem", npc_mem, e.npc);
                chk("rd_mem", {27'd0, rd_mem}, {27'd0, e.rd});
                chk("cw_mem", {27'd0, cw_mem}, {27'd0, e.cw});
            end
        end
    end

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 20) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d items left, expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        rst = 1'b0;
        r1 = 0; r2 = 0; imm_in = 0; pc_in = 0; npc_in = 0;
        cw_exe = 0; aluop_exe = 0;
        rs1_addr = 0; rs2_addr = 0; rd_in = 0;
        wb_data = 0; wb_rd = 0; wb_we = 0;
        #1;
        chk("rst_alu_mem", alu_mem, 32'd0);
        chk("rst_cw_mem", {27'd0, cw_mem}, 32'd0);
        #11;
        rst = 1'b1;

        //     r1           r2           imm          pc           npc          cw        op     rs1    rs2    rd     wbd          wbr    we    e_alu        e_st         fl    tg
        issue(32'd5,       32'd7,       32'd0,       32'h0,       32'h4,       13'h0001, 4'd0,  5'd1,  5'd2,  5'd4,  32'd0,       5'd0,  1'b0, 32'd12,      32'd7,       1'b0, 32'd0);
        issue(32'd0,       32'd0,       32'd100,     32'h4,       32'h8,       13'h0801, 4'd0,  5'd0,  5'd0,  5'd3,  32'd0,       5'd0,  1'b0, 32'd100,     32'd0,       1'b0, 32'd0);
        issue(32'd9,       32'd9,       32'd1,       32'h8,       32'hC,       13'h0801, 4'd0,  5'd3,  5'd3,  5'd0,  32'd200,     5'd3,  1'b1, 32'd101,     32'd100,     1'b0, 32'd0);
        issue(32'd7,       32'd11,      32'd1,       32'hC,       32'h10,      13'h0801, 4'd0,  5'd0,  5'd0,  5'd6,  32'd55,      5'd0,  1'b1, 32'd8,       32'd11,      1'b0, 32'd0);
        issue(32'd1,       32'd2,       32'd0,       32'h10,      32'h14,      13'h0011, 4'd1,  5'd9,  5'd6,  5'd7,  32'd40,      5'd9,  1'b1, 32'd32,      32'd8,       1'b0, 32'd0);
        issue(32'd3,       32'd4,       32'd0,       32'h14,      32'h18,      13'h0000, 4'd0,  5'd7,  5'd0,  5'd0,  32'd77,      5'd7,  1'b1, 32'd81,      32'd4,       1'b0, 32'd0);
        issue(32'hFFFFFFFF,32'd1,       32'h20,      32'h100,     32'h104,     13'h0480, 4'd0,  5'd1,  5'd2,  5'd0,  32'd0,       5'd0,  1'b0, 32'd0,       32'd1,       1'b1, 32'h120);
        issue(32'hFFFFFFFF,32'd1,       32'h20,      32'h100,     32'h104,     13'h04C0, 4'd0,  5'd1,  5'd2,  5'd0,  32'd0,       5'd0,  1'b0, 32'd0,       32'd1,       1'b0, 32'd0);
        issue(32'h203,     32'd0,       32'd4,       32'h4C,      32'h50,      13'h0901, 4'd0,  5'd1,  5'd0,  5'd1,  32'd0,       5'd0,  1'b0, 32'h207,     32'd0,       1'b1, 32'h206);
        issue(32'd0,       32'd0,       32'h10,      32'h40,      32'h44,      13'h1E40, 4'd0,  5'd2,  5'd2,  5'd0,  32'd0,       5'd0,  1'b0, 32'h50,      32'd0,       1'b1, 32'h50);
        issue(32'h1000,    32'd0,       32'h11,      32'h0,       32'h4,       13'h0B00, 4'd0,  5'd1,  5'd0,  5'd0,  32'd0,       5'd0,  1'b0, 32'h1011,    32'd0,       1'b1, 32'h1010);
        issue(32'h80000000,32'h24,      32'd0,       32'h60,      32'h64,      13'h0001, 4'd7,  5'd1,  5'd2,  5'd5,  32'd0,       5'd0,  1'b0, 32'hF8000000,32'h24,      1'b0, 32'd0);
        issue(32'hFFFFFFFF,32'd1,       32'd0,       32'h64,      32'h68,      13'h0000, 4'd9,  5'd1,  5'd2,  5'd0,  32'd0,       5'd0,  1'b0, 32'd0,       32'd1,       1'b0, 32'd0);
        issue(32'd3,       32'd4,       32'd0,       32'h68,      32'h6C,      13'h0400, 4'd10, 5'd1,  5'd2,  5'd0,  32'd0,       5'd0,  1'b0, 32'd4,       32'd4,       1'b0, 32'd0);
        issue(32'd5,       32'd5,       32'd0,       32'h6C,      32'h70,      13'h0460, 4'd8,  5'd1,  5'd2,  5'd0,  32'd0,       5'd0,  1'b0, 32'd0,       32'd5,       1'b0, 32'd0);
        issue(32'd3,       32'd4,       32'd0,       32'h70,      32'h74,      13'h0000, 4'd12, 5'd1,  5'd2,  5'd0,  32'd0,       5'd0,  1'b0, 32'd7,       32'd4,       1'b0, 32'd0);
        drain();

        // Async reset mid-cycle with a jal presented and alu_mem = 7.
        @(negedge clk);
        cw_exe = 13'h0201; rd_in = 5'd9; npc_in = 32'h99;
        #2;
        rst = 1'b0;
        #1;
        chk("async_alu_mem", alu_mem, 32'd0);
        chk("async_store", store_data_mem, 32'd0);
        chk("async_npc", npc_mem, 32'd0);
        chk("async_rd", {27'd0, rd_mem}, 32'd0);
        chk("async_cw", {27'd0, cw_mem}, 32'd0);
        chk("async_flush", {31'd0, flush}, 32'd0);
        @(posedge clk);
        #1;
        chk("held_alu_mem", alu_mem, 32'd0);
        chk("held_cw", {27'd0, cw_mem}, 32'd0);
        #2;
        rst = 1'b1;

        issue(32'd5,       32'd7,       32'd0,       32'h0,       32'h4,       13'h0001, 4'd0,  5'd1,  5'd2,  5'd4,  32'd0,       5'd0,  1'b0, 32'd12,      32'd7,       1'b0, 32'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
